sequence_generator: RTL
=======================

Name: sequence_generator

Overview:
- Serial pattern transmitter; the counterpart of sequence_detector.
- Latches an up-to-MAX_LEN-bit pattern on start and shifts it out MSB-first, one bit per clk, on x.
- Repeats the pattern repeat_count times back-to-back, or continuously until stopped.
- Drives the x input of sequence_detector in benches and in chip-level pattern-injection paths.

Parameters:
MAX_LEN, 8, maximum pattern length in bits.
LEN_W, 4, width of length port; must hold MAX_LEN.
REP_W, 4, width of repeat_count port.

Ports:
clk  input  1  clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request a transmission; sampled only in IDLE.
stop  input  1  abort the current transmission; sampled only in SHIFT.
pattern  input  MAX_LEN  bits to send; bit length-1 goes out first, bit 0 last.
length  input  LEN_W  number of pattern bits, valid range 1..MAX_LEN.
repeat_count  input  REP_W  number of pattern repetitions; 0 means continuous.
x  output  1  serial data out.
x_valid  output  1  high while x carries a pattern bit.
busy  output  1  high in SHIFT.
done  output  1  one-cycle pulse at the end of a transmission.
err  output  1  one-cycle pulse when start is rejected.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: x=0, x_valid=0, busy=0, done=0, err=0, state=IDLE, all counters 0.
- Reset has priority over all other inputs, including mid-transmission: the block returns to IDLE at the next edge with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - x=0, x_valid=0.
  - start=1 with 1<=length<=MAX_LEN: latch pattern, length and repeat_count; set idx=length-1 and rep=1; go to SHIFT.
  - start=1 with length=0 or length>MAX_LEN: stay in IDLE and pulse err for one cycle.
- Latency: in the cycle after the accepting edge, x=pattern[length-1], x_valid=1, busy=1. Zero idle cycles.
- SHIFT, one bit per cycle:
  - x = latched_pattern[idx].
  - At each edge, if idx>0, decrement idx.
  - Else, at the wrap:
    - if repeat_count==0, or rep<repeat_count: set idx=length-1 and increment rep (saturating in continuous mode); the next repetition follows with no gap.
    - otherwise go to DONE.
- stop in SHIFT: at the next edge go to DONE. The bit on x in the stop cycle counts as sent; no further bits are sent.
  - stop and the last bit in the same cycle: a single DONE; done pulses once.
- DONE: lasts exactly one cycle; done=1, busy=0, x_valid=0, x=0; then IDLE.
- Ignored inputs:
  - start in SHIFT or DONE is ignored; it is not queued.
  - stop in IDLE or DONE is ignored.
  - pattern, length and repeat_count changes after acceptance do not affect the transmission in progress.
- Total valid cycles for a finite run: length × repeat_count.
- Registered outputs only; no combinational path from inputs to outputs.

Test Plan:
- Reset, then pattern=8'b0010_1010, length=6, repeat_count=1, start pulse → x = 1,0,1,0,1,0 on the 6 cycles after acceptance with x_valid=1; done=1 on cycle 7; busy low from cycle 7. Connected sequence_detector pulses z once, after the sixth bit.
- pattern=4'b0110, length=4, repeat_count=3 → 12 contiguous valid bits 0110 0110 0110 with no x_valid gap; done after bit 12; a detector for 0110 fires 3 times.
- repeat_count=0, pattern=1010, length=4; assert stop on cycle 10 → bits 1010 1010 10 sent; x_valid low from cycle 11; exactly one done pulse.
- start held high for the whole 6-bit run, then released → first run completes normally; because start is ignored outside IDLE and not queued, no second run starts once start is low, and done pulses once.
- length=0 with start → err pulses one cycle; busy, x_valid and done stay 0. Repeat with length=9 and MAX_LEN=8 → same.
- reset asserted on the 3rd bit of a 6-bit run → next cycle all outputs 0 and no done pulse; a new start is accepted normally afterwards.

Source files
------------

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: latches an up-to-MAX_LEN-bit pattern on start and
// shifts it out MSB-first on x, repeated repeat_count times or until stopped.
module sequence_generator #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned REP_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   length,
    input  logic [REP_W-1:0]   repeat_count,
    output logic               x,
    output logic               x_valid,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [IDX_W-1:0]   lidx_q, lidx_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [REP_W-1:0]   rcnt_q, rcnt_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic               x_d, x_valid_d, busy_d, done_d, err_d;
    logic               len_ok;
    logic [IDX_W-1:0]   first_idx;

    // Next-state, counters and next output values; outputs are registered below.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        lidx_d    = lidx_q;
        idx_d     = idx_q;
        rcnt_d    = rcnt_q;
        rep_d     = rep_q;
        x_d       = 1'b0;
        x_valid_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        len_ok    = (length != '0) && (length <= LEN_W'(MAX_LEN));
        first_idx = IDX_W'(length - LEN_W'(1));

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        state_d   = S_SHIFT;
                        pat_d     = pattern;
                        lidx_d    = first_idx;
                        idx_d     = first_idx;
                        rcnt_d    = repeat_count;
                        rep_d     = REP_W'(1);
                        x_d       = pattern[first_idx];
                        x_valid_d = 1'b1;
                        busy_d    = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                if (stop) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (idx_q != '0) begin
                    idx_d     = idx_q - IDX_W'(1);
                    x_d       = pat_q[idx_d];
                    x_valid_d = 1'b1;
                    busy_d    = 1'b1;
                end else if ((rcnt_q == '0) || (rep_q < rcnt_q)) begin
                    // Wrap to the next repetition with no gap; rep saturates when continuous.
                    idx_d = lidx_q;
                    if (rep_q != '1) begin
                        rep_d = rep_q + REP_W'(1);
                    end
                    x_d       = pat_q[lidx_q];
                    x_valid_d = 1'b1;
                    busy_d    = 1'b1;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, latched transmission parameters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            lidx_q  <= '0;
            idx_q   <= '0;
            rcnt_q  <= '0;
            rep_q   <= '0;
            x       <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            lidx_q  <= lidx_d;
            idx_q   <= idx_d;
            rcnt_q  <= rcnt_d;
            rep_q   <= rep_d;
            x       <= x_d;
            x_valid <= x_valid_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
        end
    end

endmodule
